alien_laser_ctrl: RTL and testbench

Owns the alien laser pool: accepts fire requests from the alien formation, allocates one of NUM_LASERS slots, and advances each active laser down the screen once per frame. Produces the packed alien laser X/Y coordinate buses consumed by the barrier block and the ship collision logic. Consumes their per-slot hit flags to retire lasers. Also renders laser pixels for the VGA mux.

---
 rtl/si_laser_pkg.sv | 35 +++
 rtl/alien_laser_slot.sv | 105 ++++++++++
 rtl/alien_laser_ctrl.sv | 129 ++++++++++++
 tb/tb_alien_laser_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/si_laser_pkg.sv
`default_nettype none
// ============================================================================
// Module   : si_laser_pkg
// Purpose  : Shared laser geometry, park position, slot-state encoding and
//            colour for the alien laser, barrier and spaceship laser blocks.
// Revision : 1.0  initial release
// ============================================================================
package si_laser_pkg;

  localparam int         NUM_LASERS    = 3;
  localparam logic [9:0] LASER_HEIGHT  = 10'd10;
  localparam logic [9:0] LASER_WIDTH   = 10'd2;
  localparam logic [9:0] SCREEN_BOTTOM = 10'd480;
  localparam logic [9:0] SCREEN_X_MAX  = 10'd639;
  localparam logic [9:0] PARK_X        = 10'd0;
  localparam logic [9:0] PARK_Y        = 10'd0;
  localparam logic [7:0] LASER_RGB     = 8'hE0;

  typedef enum logic {
    SLOT_IDLE   = 1'b0,
    SLOT_ACTIVE = 1'b1
  } slot_state_t;

  // True when pos lies in [start, start+len); the end is formed in 11 bits so
  // a laser near the right/bottom edge never wraps.
  function automatic logic in_span(input logic [9:0] pos,
                                   input logic [9:0] start,
                                   input logic [9:0] len);
    logic [10:0] w_end;
    w_end = {1'b0, start} + {1'b0, len};
    return (pos >= start) && ({1'b0, pos} < w_end);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alien_laser_slot.sv
`default_nettype none
// ============================================================================
// Module   : alien_laser_slot
// Purpose  : One alien laser slot: IDLE/ACTIVE state, X/Y position, downward
//            motion, retire on hit or screen bottom, and pixel coverage test.
// Options  : ALIEN_LASER_AIM_EN - X steps one pixel toward i_ship_x per frame.
// Revision : 1.0  initial release
// ============================================================================
module alien_laser_slot
  import si_laser_pkg::*;
#(
  parameter logic [9:0] LASER_SPEED = 10'd4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clear,
  input  logic       i_load,
  input  logic [9:0] i_load_x,
  input  logic [9:0] i_load_y,
  input  logic       i_frame_tick,
  input  logic       i_hit,
  input  logic [9:0] i_ship_x,
  input  logic [9:0] i_pix_x,
  input  logic [9:0] i_pix_y,
  output logic       o_active,
  output logic [9:0] o_x,
  output logic [9:0] o_y,
  output logic       o_pix_hit
);

  slot_state_t r_state;
  logic [9:0]  r_x;
  logic [9:0]  r_y;
  logic [10:0] w_y_next;
  logic        w_off_screen;
  logic [9:0]  w_x_next;

  assign w_y_next     = {1'b0, r_y} + {1'b0, LASER_SPEED};
  assign w_off_screen = (w_y_next >= {1'b0, SCREEN_BOTTOM});

`ifdef ALIEN_LASER_AIM_EN
  // Horizontal homing: one pixel toward the ship, clamped to the visible width.
  always_comb begin
    w_x_next = r_x;
    if ((r_x < i_ship_x) && (r_x < SCREEN_X_MAX)) begin
      w_x_next = r_x + 10'd1;
    end else if ((r_x > i_ship_x) && (r_x != 10'd0)) begin
      w_x_next = r_x - 10'd1;
    end
  end
`else
  logic w_unused_ship_x;
  assign w_unused_ship_x = ^i_ship_x;
  assign w_x_next        = r_x;
`endif

  // Slot FSM: a hit beats motion; a fresh load does not move until the next tick.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_state <= SLOT_IDLE;
      r_x     <= PARK_X;
      r_y     <= PARK_Y;
    end else begin
      case (r_state)
        SLOT_IDLE: begin
          if (i_load) begin
            r_state <= SLOT_ACTIVE;
            r_x     <= i_load_x;
            r_y     <= i_load_y;
          end
        end
        SLOT_ACTIVE: begin
          if (i_hit) begin
            r_state <= SLOT_IDLE;
            r_x     <= PARK_X;
            r_y     <= PARK_Y;
          end else if (i_frame_tick) begin
            if (w_off_screen) begin
              r_state <= SLOT_IDLE;
              r_x     <= PARK_X;
              r_y     <= PARK_Y;
            end else begin
              r_y <= w_y_next[9:0];
              r_x <= w_x_next;
            end
          end
        end
        default: begin
          r_state <= SLOT_IDLE;
          r_x     <= PARK_X;
          r_y     <= PARK_Y;
        end
      endcase
    end
  end

  assign o_active  = (r_state == SLOT_ACTIVE);
  assign o_x       = r_x;
  assign o_y       = r_y;
  assign o_pix_hit = o_active
                   && in_span(i_pix_x, r_x, LASER_WIDTH)
                   && in_span(i_pix_y, r_y, LASER_HEIGHT);

endmodule
`default_nettype wire

// File: rtl/alien_laser_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alien_laser_ctrl
// Purpose  : Alien laser pool: allocates fire requests to the lowest free slot
//            under a frame-based cooldown, packs slot coordinates for the
//            collision blocks and renders laser pixels for the VGA mux.
// Options  : ALIEN_LASER_AIM_EN - lasers drift toward ship_x each frame.
// Revision : 1.0  initial release
// ============================================================================
module alien_laser_ctrl
  import si_laser_pkg::*;
#(
  parameter logic [9:0] LASER_SPEED   = 10'd4,
  parameter logic [5:0] FIRE_COOLDOWN = 6'd20
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mode,
  input  logic                       frame_tick,
  input  logic                       fire_req,
  input  logic [9:0]                 fire_x,
  input  logic [9:0]                 fire_y,
  input  logic [9:0]                 ship_x,
  input  logic [NUM_LASERS-1:0]      barrierHit,
  input  logic [NUM_LASERS-1:0]      shipHit,
  input  logic [9:0]                 xCoord,
  input  logic [9:0]                 yCoord,
  output logic                       fire_ack,
  output logic [10*NUM_LASERS-1:0]   alienLaserXcoord,
  output logic [10*NUM_LASERS-1:0]   alienLaserYcoord,
  output logic [NUM_LASERS-1:0]      laser_active,
  output logic                       is_alien_laser,
  output logic [7:0]                 rgb
);

  logic [NUM_LASERS-1:0] w_active;
  logic [NUM_LASERS-1:0] w_pix_hit;
  logic [NUM_LASERS-1:0] w_alloc;
  logic [NUM_LASERS-1:0] w_hit;
  logic                  w_clear;
  logic                  w_any_idle;
  logic                  w_fire_ok;
  logic [5:0]            r_cooldown;
  logic                  r_fire_ack;
  logic                  r_is_laser;
  logic [7:0]            r_rgb;

  assign w_clear    = ~mode;
  assign w_hit      = barrierHit | shipHit;
  assign w_any_idle = ~(&w_active);

  // Lowest-index idle slot as a one-hot; a slot being hit this cycle is still
  // ACTIVE here, so it only becomes allocatable on the following cycle.
  always_comb begin
    w_alloc = '0;
    for (int i = NUM_LASERS - 1; i >= 0; i--) begin
      if (!w_active[i]) begin
        w_alloc    = '0;
        w_alloc[i] = 1'b1;
      end
    end
  end

  // The r_fire_ack term keeps acks apart even if the cooldown is set to zero.
  assign w_fire_ok = fire_req && (r_cooldown == 6'd0) && w_any_idle && !r_fire_ack;

  generate
    for (genvar gi = 0; gi < NUM_LASERS; gi++) begin : g_slot
      alien_laser_slot #(
        .LASER_SPEED (LASER_SPEED)
      ) u_slot (
        .clk          (clk),
        .rst          (rst),
        .i_clear      (w_clear),
        .i_load       (w_fire_ok && w_alloc[gi]),
        .i_load_x     (fire_x),
        .i_load_y     (fire_y),
        .i_frame_tick (frame_tick),
        .i_hit        (w_hit[gi]),
        .i_ship_x     (ship_x),
        .i_pix_x      (xCoord),
        .i_pix_y      (yCoord),
        .o_active     (w_active[gi]),
        .o_x          (alienLaserXcoord[10*gi +: 10]),
        .o_y          (alienLaserYcoord[10*gi +: 10]),
        .o_pix_hit    (w_pix_hit[gi])
      );
    end
  endgenerate

  assign laser_active = w_active;

  // Launch cooldown: reload on every launch, count down once per frame.
  always_ff @(posedge clk) begin
    if (rst || w_clear) begin
      r_cooldown <= 6'd0;
    end else if (w_fire_ok) begin
      r_cooldown <= FIRE_COOLDOWN;
    end else if (frame_tick && (r_cooldown != 6'd0)) begin
      r_cooldown <= r_cooldown - 6'd1;
    end
  end

  // Single-cycle acknowledge for the cycle a request is accepted.
  always_ff @(posedge clk) begin
    if (rst || w_clear) begin
      r_fire_ack <= 1'b0;
    end else begin
      r_fire_ack <= w_fire_ok;
    end
  end

  // Pixel output registered one cycle behind the scan coordinates.
  always_ff @(posedge clk) begin
    if (rst || w_clear) begin
      r_is_laser <= 1'b0;
      r_rgb      <= 8'h00;
    end else begin
      r_is_laser <= |w_pix_hit;
      r_rgb      <= (|w_pix_hit) ? LASER_RGB : 8'h00;
    end
  end

  assign fire_ack       = r_fire_ack;
  assign is_alien_laser = r_is_laser;
  assign rgb            = r_rgb;

endmodule
`default_nettype wire

// File: tb/tb_alien_laser_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alien_laser_ctrl
// Purpose  : Scoreboard bench for alien_laser_ctrl with a slot-array model.
// Revision : 1.0  initial release
// ============================================================================
module tb_alien_laser_ctrl;

  localparam logic [9:0] TB_SPEED = 10'd4;
  localparam logic [5:0] TB_COOL  = 6'd3;
  localparam int         NL       = 3;

  logic        clk = 1'b1;
  logic        rst, mode, frame_tick, fire_req;
  logic [9:0]  fire_x, fire_y, ship_x, xCoord, yCoord;
  logic [2:0]  barrierHit, shipHit;
  logic        fire_ack, is_alien_laser;
  logic [29:0] alienLaserXcoord, alienLaserYcoord;
  logic [2:0]  laser_active;
  logic [7:0]  rgb;

  always #5 clk = ~clk;

  alien_laser_ctrl #(
    .LASER_SPEED   (TB_SPEED),
    .FIRE_COOLDOWN (TB_COOL)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .mode             (mode),
    .frame_tick       (frame_tick),
    .fire_req         (fire_req),
    .fire_x           (fire_x),
    .fire_y           (fire_y),
    .ship_x           (ship_x),
    .barrierHit       (barrierHit),
    .shipHit          (shipHit),
    .xCoord           (xCoord),
    .yCoord           (yCoord),
    .fire_ack         (fire_ack),
    .alienLaserXcoord (alienLaserXcoord),
    .alienLaserYcoord (alienLaserYcoord),
    .laser_active     (laser_active),
    .is_alien_laser   (is_alien_laser),
    .rgb              (rgb)
  );

  typedef struct {
    logic        ack;
    logic [2:0]  act;
    logic [29:0] xb;
    logic [29:0] yb;
    logic        pix;
    logic [7:0]  rgb;
  } exp_t;

  typedef struct {
    int slot;
    int x;
    int y;
  } launch_t;

  exp_t    q_exp[$];
  launch_t q_ack[$];

  // Reference pool: plain arrays of flight flags and positions.
  bit m_act[NL];
  int m_x[NL];
  int m_y[NL];
  int m_cd;
  bit m_ack;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic park(input int i);
    m_act[i] = 0;
    m_x[i]   = 0;
    m_y[i]   = 0;
  endtask

  // Predict the state visible after the coming clock edge from current inputs.
  task automatic model_step();
    exp_t    e;
    launch_t l;
    int      freeslot;
    bit      accept;
    bit      pix;
    int      xc, yc;
    logic [2:0] hit;
    hit    = barrierHit | shipHit;
    xc     = int'(xCoord);
    yc     = int'(yCoord);
    pix    = 0;
    accept = 0;
    if (rst || !mode) begin
      for (int i = 0; i < NL; i++) park(i);
      m_cd = 0;
    end else begin
      for (int i = 0; i < NL; i++)
        if (m_act[i] && xc >= m_x[i] && xc < m_x[i] + 2 && yc >= m_y[i] && yc < m_y[i] + 10)
          pix = 1;
      freeslot = -1;
      for (int i = 0; i < NL; i++)
        if (!m_act[i] && freeslot < 0) freeslot = i;
      accept = fire_req && (m_cd == 0) && (freeslot >= 0) && !m_ack;
      for (int i = 0; i < NL; i++) begin
        if (m_act[i]) begin
          if (hit[i]) park(i);
          else if (frame_tick) begin
            if (m_y[i] + int'(TB_SPEED) >= 480) park(i);
            else begin
              m_y[i] = m_y[i] + int'(TB_SPEED);
`ifdef ALIEN_LASER_AIM_EN
              if (m_x[i] < int'(ship_x) && m_x[i] < 639) m_x[i] = m_x[i] + 1;
              else if (m_x[i] > int'(ship_x)) m_x[i] = m_x[i] - 1;
`endif
            end
          end
        end else if (accept && i == freeslot) begin
          m_act[i] = 1;
          m_x[i]   = int'(fire_x);
          m_y[i]   = int'(fire_y);
        end
      end
      if (accept) m_cd = int'(TB_COOL);
      else if (frame_tick && m_cd > 0) m_cd = m_cd - 1;
      if (accept) begin
        l.slot = freeslot;
        l.x    = int'(fire_x);
        l.y    = int'(fire_y);
        q_ack.push_back(l);
      end
    end
    m_ack = accept;
    e.ack = accept;
    e.pix = pix;
    e.rgb = pix ? 8'hE0 : 8'h00;
    e.xb  = '0;
    e.yb  = '0;
    for (int i = 0; i < NL; i++) begin
      e.act[i]        = m_act[i];
      e.xb[10*i +: 10] = 10'(m_x[i]);
      e.yb[10*i +: 10] = 10'(m_y[i]);
    end
    q_exp.push_back(e);
  endtask

  task automatic commit();
    model_step();
    @(negedge clk);
  endtask

  // Monitor: compare each presented cycle, and each ack against its launch.
  initial begin : monitor
    exp_t    e;
    launch_t l;
    forever begin
      @(posedge clk);
      #1;
      if (q_exp.size() != 0) begin
        e = q_exp.pop_front();
        chk("fire_ack", {31'd0, fire_ack}, {31'd0, e.ack});
        chk("laser_active", {29'd0, laser_active}, {29'd0, e.act});
        chk("xcoord_bus", {2'd0, alienLaserXcoord}, {2'd0, e.xb});
        chk("ycoord_bus", {2'd0, alienLaserYcoord}, {2'd0, e.yb});
        chk("is_alien_laser", {31'd0, is_alien_laser}, {31'd0, e.pix});
        chk("rgb", {24'd0, rgb}, {24'd0, e.rgb});
        if (fire_ack === 1'b1 || e.ack) begin
          if (q_ack.size() == 0) begin
            chk("ack_expected", {31'd0, fire_ack}, 32'd0);
          end else begin
            l = q_ack.pop_front();
            if (fire_ack === 1'b1) begin
              chk("launch_active", {31'd0, laser_active[l.slot]}, 32'd1);
              chk("launch_x", {22'd0, alienLaserXcoord[10*l.slot +: 10]}, 32'(l.x));
              chk("launch_y", {22'd0, alienLaserYcoord[10*l.slot +: 10]}, 32'(l.y));
            end
          end
        end
      end
    end
  end

  // Stimulus: directed opening, then randomized play.
  initial begin : driver
    int k, px, py;
    rst = 1'b1; mode = 1'b0; frame_tick = 1'b0; fire_req = 1'b0;
    fire_x = '0; fire_y = '0; ship_x = 10'd320;
    barrierHit = '0; shipHit = '0; xCoord = '0; yCoord = '0;
    for (int i = 0; i < NL; i++) park(i);
    m_cd = 0; m_ack = 0;
    @(negedge clk);
    repeat (3) commit();
    chk("reset_active", {29'd0, laser_active}, 32'd0);
    chk("reset_ack", {31'd0, fire_ack}, 32'd0);

    rst = 1'b0; mode = 1'b1;
    fire_req = 1'b1; fire_x = 10'd100; fire_y = 10'd50;
    commit();
    chk("dir_ack", {31'd0, fire_ack}, 32'd1);
    chk("dir_x0", {22'd0, alienLaserXcoord[9:0]}, 32'd100);
    chk("dir_y0", {22'd0, alienLaserYcoord[9:0]}, 32'd50);
    fire_req = 1'b0;
    commit();
    chk("dir_ack_pulse", {31'd0, fire_ack}, 32'd0);
    for (int t = 0; t < 5; t++) begin
      frame_tick = 1'b1; commit();
      frame_tick = 1'b0; commit();
    end
    chk("dir_y70", {22'd0, alienLaserYcoord[9:0]}, 32'd70);
    xCoord = 10'd101; yCoord = 10'd79; commit();
    chk("dir_pix_in", {31'd0, is_alien_laser}, 32'd1);
    chk("dir_rgb_in", {24'd0, rgb}, 32'hE0);
    xCoord = 10'd102; yCoord = 10'd79; commit();
    chk("dir_pix_out", {31'd0, is_alien_laser}, 32'd0);

    for (int c = 0; c < 4000; c++) begin
      if (m_ack) fire_req = 1'b0;
      if (!fire_req && $urandom_range(0, 2) == 0) begin
        fire_req = 1'b1;
        fire_x   = 10'($urandom_range(0, 639));
        fire_y   = 10'($urandom_range(0, 470));
      end
      frame_tick = ($urandom_range(0, 3) == 0);
      barrierHit = ($urandom_range(0, 11) == 0) ? 3'($urandom_range(0, 7)) : 3'd0;
      shipHit    = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(0, 7)) : 3'd0;
      mode       = ($urandom_range(0, 299) != 0);
      rst        = ($urandom_range(0, 999) == 0);
      if ($urandom_range(0, 19) == 0) ship_x = 10'($urandom_range(0, 639));
      if ($urandom_range(0, 1) == 0) begin
        k  = $urandom_range(0, NL - 1);
        px = m_x[k] + $urandom_range(0, 3) - 1;
        py = m_y[k] + $urandom_range(0, 11) - 1;
        if (px < 0) px = 0;
        if (py < 0) py = 0;
        xCoord = 10'(px);
        yCoord = 10'(py);
      end else begin
        xCoord = 10'($urandom_range(0, 639));
        yCoord = 10'($urandom_range(0, 479));
      end
      commit();
    end

    @(posedge clk);
    #3;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
